// File: rtl/button_debouncer.sv
// Push-button front end: two-flop synchronizer, debounce FSM, and registered
// press/release/click/long strobes plus an 8-bit press counter.
module button_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 240_000,
   parameter int unsigned LONG_CYCLES     = 24_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btnx,
   output logic       pressed,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       click_pulse,
   output logic       long_pulse,
   output logic [7:0] press_count
);

   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HW = $clog2(LONG_CYCLES + 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      HELD_LONG,
      RELEASE_WAIT
   } state_t;

   state_t        state;
   logic          sync_1;
   logic          sync_2;
   logic          btn_s;
   logic          long_flag;
   logic [DW-1:0] deb_cnt;
   logic [HW-1:0] hold_cnt;

   assign btn_s = ~sync_2;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_1        <= 1'b1;
         sync_2        <= 1'b1;
         state         <= IDLE;
         deb_cnt       <= '0;
         hold_cnt      <= '0;
         long_flag     <= 1'b0;
         pressed       <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         click_pulse   <= 1'b0;
         long_pulse    <= 1'b0;
         press_count   <= '0;
      end else begin
         sync_1        <= btnx;
         sync_2        <= sync_1;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         click_pulse   <= 1'b0;
         long_pulse    <= 1'b0;

         // The cycle leaving IDLE/HELD is already the first counted
         // disagreeing cycle, so the debounce count starts at 1 there.
         case (state)
            IDLE: begin
               if (btn_s) begin
                  state   <= PRESS_WAIT;
                  deb_cnt <= DW'(1);
               end else begin
                  deb_cnt <= '0;
               end
            end

            PRESS_WAIT: begin
               if (!btn_s) begin
                  state   <= IDLE;
                  deb_cnt <= '0;
               end else if (deb_cnt == DEB_LAST) begin
                  state       <= HELD;
                  deb_cnt     <= '0;
                  hold_cnt    <= '0;
                  pressed     <= 1'b1;
                  press_pulse <= 1'b1;
                  press_count <= press_count + 8'd1;
               end else begin
                  deb_cnt <= deb_cnt + DW'(1);
               end
            end

            HELD: begin
               hold_cnt <= hold_cnt + HW'(1);
               if (hold_cnt == HOLD_LAST) begin
                  long_flag  <= 1'b1;
                  long_pulse <= 1'b1;
               end
               // Long threshold and release start may coincide; the long
               // flag routes a later bounce back into HELD_LONG.
               if (!btn_s) begin
                  state   <= RELEASE_WAIT;
                  deb_cnt <= DW'(1);
               end else if (hold_cnt == HOLD_LAST) begin
                  state <= HELD_LONG;
               end
            end

            HELD_LONG: begin
               if (!btn_s) begin
                  state   <= RELEASE_WAIT;
                  deb_cnt <= DW'(1);
               end
            end

            RELEASE_WAIT: begin
               if (btn_s) begin
                  state   <= long_flag ? HELD_LONG : HELD;
                  deb_cnt <= '0;
               end else if (deb_cnt == DEB_LAST) begin
                  state         <= IDLE;
                  deb_cnt       <= '0;
                  pressed       <= 1'b0;
                  release_pulse <= 1'b1;
                  click_pulse   <= ~long_flag;
                  long_flag     <= 1'b0;
               end else begin
                  deb_cnt <= deb_cnt + DW'(1);
               end
            end

            default: begin
               state   <= IDLE;
               deb_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios plus random button activity,
// compared cycle by cycle against a run-length reference model.
module tb_button_debouncer;

   localparam int unsigned D = 4;
   localparam int unsigned L = 20;

   logic       clk = 1'b0;
   logic       rst;
   logic       btnx;
   logic       pressed;
   logic       press_pulse;
   logic       release_pulse;
   logic       click_pulse;
   logic       long_pulse;
   logic [7:0] press_count;

   always #5 clk = ~clk;

   button_debouncer #(
      .DEBOUNCE_CYCLES(D),
      .LONG_CYCLES    (L)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .btnx         (btnx),
      .pressed      (pressed),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .click_pulse  (click_pulse),
      .long_pulse   (long_pulse),
      .press_count  (press_count)
   );

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   int unsigned cyc   = 0;

   // reference model: pipeline of raw samples, accepted level, disagreeing run
   bit          m_s1, m_s2;
   bit          m_lvl, m_long;
   int unsigned m_run, m_hold, m_cnt;
   bit          m_pp, m_rp, m_cp, m_lp;

   // observed strobe history
   int unsigned n_press = 0, n_rel = 0, n_click = 0, n_long = 0;
   int unsigned press_edge = 0, rel_edge = 0, click_edge = 0, long_edge = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_step(input bit r, input bit b_raw);
      bit b;
      m_pp = 0; m_rp = 0; m_cp = 0; m_lp = 0;
      if (r) begin
         m_s1 = 1; m_s2 = 1; m_lvl = 0; m_long = 0;
         m_run = 0; m_hold = 0; m_cnt = 0;
      end else begin
         b    = !m_s2;
         m_s2 = m_s1;
         m_s1 = b_raw;
         // hold time accrues only while pressed with no pending release
         if (m_lvl && m_run == 0 && !m_long) begin
            m_hold++;
            if (m_hold == L) begin
               m_long = 1;
               m_lp   = 1;
            end
         end
         if (b != m_lvl) begin
            m_run++;
            if (m_run == D + 1) begin
               m_run = 0;
               m_lvl = b;
               if (b) begin
                  m_pp   = 1;
                  m_cnt  = (m_cnt + 1) % 256;
                  m_hold = 0;
               end else begin
                  m_rp   = 1;
                  m_cp   = !m_long;
                  m_long = 0;
               end
            end
         end else begin
            m_run = 0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      model_step(rst, btnx);
      @(negedge clk);
      check("pressed",       32'(pressed),       32'(m_lvl));
      check("press_pulse",   32'(press_pulse),   32'(m_pp));
      check("release_pulse", 32'(release_pulse), 32'(m_rp));
      check("click_pulse",   32'(click_pulse),   32'(m_cp));
      check("long_pulse",    32'(long_pulse),    32'(m_lp));
      check("press_count",   32'(press_count),   32'(m_cnt));
      if (press_pulse === 1'b1)   begin n_press++; press_edge = cyc; end
      if (release_pulse === 1'b1) begin n_rel++;   rel_edge   = cyc; end
      if (click_pulse === 1'b1)   begin n_click++; click_edge = cyc; end
      if (long_pulse === 1'b1)    begin n_long++;  long_edge  = cyc; end
   endtask

   task automatic drive(input bit v, input int unsigned n);
      btnx = v;
      for (int unsigned i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset(input int unsigned n);
      rst = 1'b1;
      for (int unsigned i = 0; i < n; i++) tick();
      rst = 1'b0;
   endtask

   initial begin
      int unsigned e0, e1, p0, r0, c0, l0;
      rst  = 1'b1;
      btnx = 1'b1;
      do_reset(3);
      drive(1, 4);

      // clean short press
      p0 = n_press; r0 = n_rel; c0 = n_click; l0 = n_long;
      e0 = cyc + 1;
      drive(0, 12);
      e1 = cyc + 1;
      drive(1, 10);
      check("clean_press_edge",   press_edge, e0 + 2 + D);
      check("clean_release_edge", rel_edge,   e1 + 2 + D);
      check("clean_click_edge",   click_edge, e1 + 2 + D);
      check("clean_count",        32'(press_count), 1);
      check("clean_no_long",      n_long - l0, 0);
      check("clean_npress",       n_press - p0, 1);

      // press bounce
      p0 = n_press;
      drive(0, 3);
      drive(1, 1);
      e0 = cyc + 1;
      drive(0, 10);
      check("bounce_press_edge", press_edge, e0 + 2 + D);
      check("bounce_npress",     n_press - p0, 1);
      drive(1, 10);

      // long press
      p0 = n_press; r0 = n_rel; c0 = n_click; l0 = n_long;
      e0 = cyc + 1;
      drive(0, 40);
      drive(1, 10);
      check("long_edge",     long_edge, e0 + 2 + D + L);
      check("long_nlong",    n_long - l0, 1);
      check("long_nrelease", n_rel - r0, 1);
      check("long_noclick",  n_click - c0, 0);

      // release bounce while in HELD_LONG
      r0 = n_rel; c0 = n_click; l0 = n_long;
      drive(0, 30);
      drive(1, 2);
      drive(0, 10);
      check("relbounce_norelease", n_rel - r0, 0);
      check("relbounce_pressed",   32'(pressed), 1);
      drive(1, 10);
      check("relbounce_nrelease", n_rel - r0, 1);
      check("relbounce_noclick",  n_click - c0, 0);
      check("relbounce_nlong",    n_long - l0, 1);

      // counter wrap
      do_reset(2);
      p0 = n_press;
      for (int unsigned i = 0; i < 257; i++) begin
         drive(0, 8);
         drive(1, 8);
      end
      check("wrap_count",  32'(press_count), 1);
      check("wrap_npress", n_press - p0, 257);

      // reset while held
      drive(0, 12);
      btnx = 1'b0;
      do_reset(3);
      check("rst_pressed", 32'(pressed), 0);
      check("rst_count",   32'(press_count), 0);
      p0 = n_press;
      e0 = cyc + 1;
      drive(0, 10);
      check("rst_press_edge", press_edge, e0 + 2 + D);
      check("rst_npress",     n_press - p0, 1);
      check("rst_count_after", 32'(press_count), 1);
      drive(1, 10);

      // random activity
      for (int unsigned i = 0; i < 300; i++) begin
         int unsigned len;
         len = $urandom_range(1, 9);
         if ($urandom_range(0, 7) == 0) len = $urandom_range(15, 45);
         if ($urandom_range(0, 59) == 0) begin
            btnx = 1'($urandom_range(0, 1));
            do_reset($urandom_range(1, 3));
         end else begin
            drive(1'($urandom_range(0, 1)), len);
         end
      end
      drive(1, 12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
